// File: rtl/operand_entry.sv
// Assembles two BCD operands and an operator from decoded keypad codes and
// hands the operation to the arithmetic unit with a valid/done handshake.
module operand_entry #(
    parameter int DIGITS = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [3:0]            key,
    input  logic                  keytype,
    input  logic                  key_strobe,
    input  logic                  calc_done,
    input  logic [4*DIGITS-1:0]   result_bcd,
    output logic [4*DIGITS-1:0]   operand_a,
    output logic [4*DIGITS-1:0]   operand_b,
    output logic [1:0]            op_code,
    output logic                  calc_valid,
    output logic [4*DIGITS-1:0]   display,
    output logic                  overflow,
    output logic [2:0]            state
);

    localparam int W  = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_OP   = 3'd1,
        S_B    = 3'd2,
        S_CALC = 3'd3,
        S_RES  = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    operand_a_q, operand_a_d;
    logic [W-1:0]    operand_b_q, operand_b_d;
    logic [1:0]      op_code_q, op_code_d;
    logic            calc_valid_q, calc_valid_d;
    logic [W-1:0]    display_q, display_d;
    logic            overflow_q, overflow_d;
    logic [CW-1:0]   cnt_a_q, cnt_a_d;
    logic [CW-1:0]   cnt_b_q, cnt_b_d;

    logic is_digit, is_op, is_eq, is_clr;

    // Returns {overflow, new count, new value}; a full operand rejects the digit.
    function automatic logic [CW+W:0] append_digit(input logic [W-1:0]  val,
                                                   input logic [CW-1:0] cnt,
                                                   input logic [3:0]    digit);
        logic [CW+W:0] r;
        r = {1'b0, cnt, val};
        if (cnt == CW'(DIGITS))
            r = {1'b1, cnt, val};
        else if (cnt != '0 || digit != 4'd0)
            r = {1'b0, cnt + 1'b1, (val << 4) | W'(digit)};
        return r;
    endfunction

    assign is_digit = key_strobe &&  keytype && (key <= 4'd9);
    assign is_op    = key_strobe && !keytype && (key >= 4'hA) && (key <= 4'hD);
    assign is_eq    = key_strobe && !keytype && (key == 4'hE);
    assign is_clr   = key_strobe && !keytype && (key == 4'hF);

    always_comb begin
        state_d      = state_q;
        operand_a_d  = operand_a_q;
        operand_b_d  = operand_b_q;
        op_code_d    = op_code_q;
        calc_valid_d = calc_valid_q;
        overflow_d   = 1'b0;
        cnt_a_d      = cnt_a_q;
        cnt_b_d      = cnt_b_q;

        if (is_clr && state_q != S_CALC) begin
            state_d      = S_A;
            operand_a_d  = '0;
            operand_b_d  = '0;
            op_code_d    = 2'd0;
            calc_valid_d = 1'b0;
            cnt_a_d      = '0;
            cnt_b_d      = '0;
        end else begin
            case (state_q)
                S_A: begin
                    if (is_digit) begin
                        {overflow_d, cnt_a_d, operand_a_d} = append_digit(operand_a_q, cnt_a_q, key);
                    end else if (is_op) begin
                        op_code_d   = key[1:0] - 2'd2;
                        operand_b_d = '0;
                        cnt_b_d     = '0;
                        state_d     = S_OP;
                    end
                end
                S_OP: begin
                    if (is_op) begin
                        op_code_d = key[1:0] - 2'd2;
                    end else if (is_digit) begin
                        {overflow_d, cnt_b_d, operand_b_d} = append_digit('0, '0, key);
                        state_d = S_B;
                    end
                end
                S_B: begin
                    if (is_digit) begin
                        {overflow_d, cnt_b_d, operand_b_d} = append_digit(operand_b_q, cnt_b_q, key);
                    end else if (is_eq) begin
                        calc_valid_d = 1'b1;
                        state_d      = S_CALC;
                    end
                end
                S_CALC: begin
                    // Keys are dropped here so the operands stay frozen for the request.
                    if (calc_done) begin
                        operand_a_d  = result_bcd;
                        cnt_a_d      = CW'(DIGITS);
                        calc_valid_d = 1'b0;
                        state_d      = S_RES;
                    end
                end
                S_RES: begin
                    if (is_digit) begin
                        {overflow_d, cnt_a_d, operand_a_d} = append_digit('0, '0, key);
                        state_d = S_A;
                    end else if (is_op) begin
                        op_code_d   = key[1:0] - 2'd2;
                        operand_b_d = '0;
                        cnt_b_d     = '0;
                        state_d     = S_OP;
                    end
                end
                default: state_d = S_A;
            endcase
        end

        display_d = (state_d == S_B || state_d == S_CALC) ? operand_b_d : operand_a_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_A;
            operand_a_q  <= '0;
            operand_b_q  <= '0;
            op_code_q    <= 2'd0;
            calc_valid_q <= 1'b0;
            display_q    <= '0;
            overflow_q   <= 1'b0;
            cnt_a_q      <= '0;
            cnt_b_q      <= '0;
        end else begin
            state_q      <= state_d;
            operand_a_q  <= operand_a_d;
            operand_b_q  <= operand_b_d;
            op_code_q    <= op_code_d;
            calc_valid_q <= calc_valid_d;
            display_q    <= display_d;
            overflow_q   <= overflow_d;
            cnt_a_q      <= cnt_a_d;
            cnt_b_q      <= cnt_b_d;
        end
    end

    assign operand_a  = operand_a_q;
    assign operand_b  = operand_b_q;
    assign op_code    = op_code_q;
    assign calc_valid = calc_valid_q;
    assign display    = display_q;
    assign overflow   = overflow_q;
    assign state      = state_q;

endmodule

// File: tb/tb_operand_entry.sv
// Directed, table-driven bench for operand_entry: one record per clock cycle
// with hand-computed register values expected after that edge.
module tb_operand_entry;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    logic           clock = 1'b0;
    logic           reset;
    logic [3:0]     key;
    logic           keytype;
    logic           key_strobe;
    logic           calc_done;
    logic [W-1:0]   result_bcd;
    logic [W-1:0]   operand_a;
    logic [W-1:0]   operand_b;
    logic [1:0]     op_code;
    logic           calc_valid;
    logic [W-1:0]   display;
    logic           overflow;
    logic [2:0]     state;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic         rst;
        logic         stb;
        logic         kt;
        logic [3:0]   k;
        logic         done;
        logic [W-1:0] res;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [1:0]   op;
        logic         cv;
        logic [W-1:0] disp;
        logic         ovf;
        logic [2:0]   st;
    } vec_t;

    vec_t vecs[$];

    operand_entry #(.DIGITS(DIGITS)) dut (
        .clock      (clock),
        .reset      (reset),
        .key        (key),
        .keytype    (keytype),
        .key_strobe (key_strobe),
        .calc_done  (calc_done),
        .result_bcd (result_bcd),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .op_code    (op_code),
        .calc_valid (calc_valid),
        .display    (display),
        .overflow   (overflow),
        .state      (state)
    );

    always #5 clock = ~clock;

    function automatic vec_t mk(input logic rst, input logic stb, input logic kt,
                                input logic [3:0] k, input logic done, input logic [W-1:0] res,
                                input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op,
                                input logic cv, input logic [W-1:0] disp, input logic ovf,
                                input logic [2:0] st);
        vec_t v;
        v.rst = rst; v.stb = stb; v.kt = kt; v.k = k; v.done = done; v.res = res;
        v.a = a; v.b = b; v.op = op; v.cv = cv; v.disp = disp; v.ovf = ovf; v.st = st;
        return v;
    endfunction

    task automatic applyStimulus(input logic rst, input logic stb, input logic kt,
                                 input logic [3:0] k, input logic done, input logic [W-1:0] res);
        reset      = rst;
        key_strobe = stb;
        keytype    = kt;
        key        = k;
        calc_done  = done;
        result_bcd = res;
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [1:0] op, input logic cv, input logic [W-1:0] disp,
                               input logic ovf, input logic [2:0] st);
        logic [54:0] act, exp;
        act = {operand_a, operand_b, op_code, calc_valid, display, overflow, state};
        exp = {a, b, op, cv, disp, ovf, st};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got a=%h b=%h op=%0d cv=%b disp=%h ovf=%b st=%0d, want a=%h b=%h op=%0d cv=%b disp=%h ovf=%b st=%0d",
                     name, operand_a, operand_b, op_code, calc_valid, display, overflow, state,
                     a, b, op, cv, disp, ovf, st);
        end
    endtask

    initial begin
        reset = 1'b1; key_strobe = 1'b0; keytype = 1'b0; key = 4'h0;
        calc_done = 1'b0; result_bcd = '0;

        //           rst stb kt key  done res        a        b        op cv disp     ovf st
        // 1,2,+,3,= then result 15, chain *,2,=
        vecs.push_back(mk(1, 0, 0, 4'h0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0));
        vecs.push_back(mk(0, 1, 1, 4'h1, 0, 16'h0000, 16'h0001, 16'h0000, 0, 0, 16'h0001, 0, 0));
        vecs.push_back(mk(0, 1, 1, 4'h2, 0, 16'h0000, 16'h0012, 16'h0000, 0, 0, 16'h0012, 0, 0));
        vecs.push_back(mk(0, 1, 0, 4'hA, 0, 16'h0000, 16'h0012, 16'h0000, 0, 0, 16'h0012, 0, 1));
        vecs.push_back(mk(0, 1, 1, 4'h3, 0, 16'h0000, 16'h0012, 16'h0003, 0, 0, 16'h0003, 0, 2));
        vecs.push_back(mk(0, 1, 0, 4'hE, 0, 16'h0000, 16'h0012, 16'h0003, 0, 1, 16'h0003, 0, 3));
        vecs.push_back(mk(0, 0, 0, 4'h0, 0, 16'h0000, 16'h0012, 16'h0003, 0, 1, 16'h0003, 0, 3));
        vecs.push_back(mk(0, 0, 0, 4'h0, 1, 16'h0015, 16'h0015, 16'h0003, 0, 0, 16'h0015, 0, 4));
        vecs.push_back(mk(0, 1, 0, 4'hC, 0, 16'h0000, 16'h0015, 16'h0000, 2, 0, 16'h0015, 0, 1));
        vecs.push_back(mk(0, 1, 1, 4'h2, 0, 16'h0000, 16'h0015, 16'h0002, 2, 0, 16'h0002, 0, 2));
        vecs.push_back(mk(0, 1, 0, 4'hE, 0, 16'h0000, 16'h0015, 16'h0002, 2, 1, 16'h0002, 0, 3));
        // keys in S_CALC are dropped, including clear and a key coincident with done
        vecs.push_back(mk(0, 1, 0, 4'hF, 0, 16'h0000, 16'h0015, 16'h0002, 2, 1, 16'h0002, 0, 3));
        vecs.push_back(mk(0, 1, 1, 4'h5, 0, 16'h0000, 16'h0015, 16'h0002, 2, 1, 16'h0002, 0, 3));
        vecs.push_back(mk(0, 1, 1, 4'h7, 1, 16'h0042, 16'h0042, 16'h0002, 2, 0, 16'h0042, 0, 4));
        vecs.push_back(mk(0, 1, 0, 4'hF, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0));
        // leading zeros, then fill and overflow on the fifth digit
        vecs.push_back(mk(0, 1, 1, 4'h0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0));
        vecs.push_back(mk(0, 1, 1, 4'h0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0));
        vecs.push_back(mk(0, 1, 1, 4'h7, 0, 16'h0000, 16'h0007, 16'h0000, 0, 0, 16'h0007, 0, 0));
        vecs.push_back(mk(0, 1, 1, 4'h1, 0, 16'h0000, 16'h0071, 16'h0000, 0, 0, 16'h0071, 0, 0));
        vecs.push_back(mk(0, 1, 1, 4'h2, 0, 16'h0000, 16'h0712, 16'h0000, 0, 0, 16'h0712, 0, 0));
        vecs.push_back(mk(0, 1, 1, 4'h3, 0, 16'h0000, 16'h7123, 16'h0000, 0, 0, 16'h7123, 0, 0));
        vecs.push_back(mk(0, 1, 1, 4'h4, 0, 16'h0000, 16'h7123, 16'h0000, 0, 0, 16'h7123, 1, 0));
        vecs.push_back(mk(0, 0, 0, 4'h0, 0, 16'h0000, 16'h7123, 16'h0000, 0, 0, 16'h7123, 0, 0));
        // 5,+,- then clear
        vecs.push_back(mk(0, 1, 0, 4'hF, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0));
        vecs.push_back(mk(0, 1, 1, 4'h5, 0, 16'h0000, 16'h0005, 16'h0000, 0, 0, 16'h0005, 0, 0));
        vecs.push_back(mk(0, 1, 0, 4'hA, 0, 16'h0000, 16'h0005, 16'h0000, 0, 0, 16'h0005, 0, 1));
        vecs.push_back(mk(0, 1, 0, 4'hB, 0, 16'h0000, 16'h0005, 16'h0000, 1, 0, 16'h0005, 0, 1));
        vecs.push_back(mk(0, 1, 0, 4'hF, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0));
        // digit keytype with code > 9 and '=' in S_A are ignored
        vecs.push_back(mk(0, 1, 1, 4'hC, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0));
        vecs.push_back(mk(0, 1, 0, 4'hE, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0));
        // reset while calc_valid is high, then a late done
        vecs.push_back(mk(0, 1, 1, 4'h9, 0, 16'h0000, 16'h0009, 16'h0000, 0, 0, 16'h0009, 0, 0));
        vecs.push_back(mk(0, 1, 0, 4'hA, 0, 16'h0000, 16'h0009, 16'h0000, 0, 0, 16'h0009, 0, 1));
        vecs.push_back(mk(0, 1, 1, 4'h8, 0, 16'h0000, 16'h0009, 16'h0008, 0, 0, 16'h0008, 0, 2));
        vecs.push_back(mk(0, 1, 0, 4'hE, 0, 16'h0000, 16'h0009, 16'h0008, 0, 1, 16'h0008, 0, 3));
        vecs.push_back(mk(1, 0, 0, 4'h0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0));
        vecs.push_back(mk(0, 0, 0, 4'h0, 1, 16'h0099, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0));
        // digit in S_RES restarts A (zero rule applies)
        vecs.push_back(mk(0, 1, 1, 4'h1, 0, 16'h0000, 16'h0001, 16'h0000, 0, 0, 16'h0001, 0, 0));
        vecs.push_back(mk(0, 1, 0, 4'hB, 0, 16'h0000, 16'h0001, 16'h0000, 1, 0, 16'h0001, 0, 1));
        vecs.push_back(mk(0, 1, 1, 4'h1, 0, 16'h0000, 16'h0001, 16'h0001, 1, 0, 16'h0001, 0, 2));
        vecs.push_back(mk(0, 1, 0, 4'hE, 0, 16'h0000, 16'h0001, 16'h0001, 1, 1, 16'h0001, 0, 3));
        vecs.push_back(mk(0, 0, 0, 4'h0, 1, 16'h0123, 16'h0123, 16'h0001, 1, 0, 16'h0123, 0, 4));
        vecs.push_back(mk(0, 1, 1, 4'h0, 0, 16'h0000, 16'h0000, 16'h0001, 1, 0, 16'h0000, 0, 0));
        vecs.push_back(mk(0, 1, 1, 4'h6, 0, 16'h0000, 16'h0006, 16'h0001, 1, 0, 16'h0006, 0, 0));
        // done outside S_CALC, '=' in S_OP, operator in S_B are all ignored
        vecs.push_back(mk(0, 0, 0, 4'h0, 1, 16'h9999, 16'h0006, 16'h0001, 1, 0, 16'h0006, 0, 0));
        vecs.push_back(mk(0, 1, 0, 4'hA, 0, 16'h0000, 16'h0006, 16'h0000, 0, 0, 16'h0006, 0, 1));
        vecs.push_back(mk(0, 1, 0, 4'hE, 0, 16'h0000, 16'h0006, 16'h0000, 0, 0, 16'h0006, 0, 1));
        vecs.push_back(mk(0, 1, 1, 4'h5, 0, 16'h0000, 16'h0006, 16'h0005, 0, 0, 16'h0005, 0, 2));
        vecs.push_back(mk(0, 1, 0, 4'hD, 0, 16'h0000, 16'h0006, 16'h0005, 0, 0, 16'h0005, 0, 2));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].stb, vecs[i].kt, vecs[i].k, vecs[i].done, vecs[i].res);
            checkOutput($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].cv,
                        vecs[i].disp, vecs[i].ovf, vecs[i].st);
        end

        // Request held with stable operands across a slow arithmetic unit, then chain '-'
        applyStimulus(0, 1, 0, 4'hE, 0, 16'h0000);
        checkOutput("hold_req", 16'h0006, 16'h0005, 2'd0, 1'b1, 16'h0005, 1'b0, 3'd3);
        for (int c = 0; c < 5; c++) begin
            applyStimulus(0, 0, 0, 4'h0, 0, 16'h0000);
            checkOutput($sformatf("hold_wait%0d", c), 16'h0006, 16'h0005, 2'd0, 1'b1, 16'h0005, 1'b0, 3'd3);
        end
        applyStimulus(0, 0, 0, 4'h0, 1, 16'h0011);
        checkOutput("hold_done", 16'h0011, 16'h0005, 2'd0, 1'b0, 16'h0011, 1'b0, 3'd4);
        applyStimulus(0, 1, 0, 4'hB, 0, 16'h0000);
        checkOutput("chain_op", 16'h0011, 16'h0000, 2'd1, 1'b0, 16'h0011, 1'b0, 3'd1);
        applyStimulus(0, 0, 0, 4'h0, 0, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
